// File: rtl/digit_serial_mult.sv
// Digit-serial multiplier: parallel operands in, 2N-bit product streamed out
// LSB digit first, P bits per digit, with runtime width and signed mode.
module digit_serial_mult #(
  parameter  int P         = 2,
  parameter  int MAX_WIDTH = 16,
  localparam int MAX_D     = MAX_WIDTH / P,
  localparam int ND_W      = $clog2(MAX_D) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAX_WIDTH-1:0] a,
  input  logic [MAX_WIDTH-1:0] b,
  input  logic [ND_W-1:0]      num_digits,
  input  logic                 signed_mode,
  output logic                 p_valid,
  input  logic                 p_ready,
  output logic [P-1:0]         p,
  output logic                 p_last,
  output logic                 busy
);
  localparam int K_W   = ND_W + 1;
  localparam int ACC_W = 2*P + $clog2(MAX_D) + 1;
  localparam int NW    = $clog2(MAX_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] a_mag;
    logic [MAX_WIDTH-1:0] b_mag;
    logic [ND_W-1:0]      d;
    logic                 neg;
  } op_t;

  state_t             state, state_nxt;
  op_t                op, op_new;
  logic [ACC_W-1:0]   acc;
  logic [K_W-1:0]     k, i;
  logic               ncarry;
  logic [P-1:0]       p_reg;
  logic               p_last_reg;

  // first/last multiplicand digit index contributing to column k
  function automatic logic [K_W-1:0] col_lo(input logic [K_W-1:0] kk, input logic [ND_W-1:0] dd);
    return (kk >= K_W'(dd)) ? kk - K_W'(dd) + 1'b1 : '0;
  endfunction

  function automatic logic [K_W-1:0] col_hi(input logic [K_W-1:0] kk, input logic [ND_W-1:0] dd);
    return (kk < K_W'(dd)) ? kk : K_W'(dd) - 1'b1;
  endfunction

  // operand capture: effective width, sign detect and magnitude
  logic [ND_W-1:0]      d_eff;
  logic [NW-1:0]        n_eff;
  logic [MAX_WIDTH-1:0] mask, top;
  logic                 sa, sb;

  always_comb begin
    d_eff = (num_digits == '0 || num_digits > ND_W'(MAX_D)) ? ND_W'(MAX_D) : num_digits;
    n_eff = NW'(d_eff) * NW'(P);
    mask  = {MAX_WIDTH{1'b1}} >> (NW'(MAX_WIDTH) - n_eff);
    top   = mask ^ (mask >> 1);
    sa    = signed_mode & (|(a & top));
    sb    = signed_mode & (|(b & top));
    op_new.a_mag = (sa ? (~a + 1'b1) : a) & mask;
    op_new.b_mag = (sb ? (~b + 1'b1) : b) & mask;
    op_new.d     = d_eff;
    op_new.neg   = sa ^ sb;
  end

  // column datapath and sign-fixup of the outgoing digit
  logic [P-1:0]     a_dig, b_dig, close_d, out_d;
  logic [2*P-1:0]   pp;
  logic [ACC_W-1:0] s;
  logic [P:0]       tneg;
  logic             nc_nxt, last_pair;
  logic [K_W-1:0]   k_pen;

  always_comb begin
    a_dig     = P'(op.a_mag >> (i * P));
    b_dig     = P'(op.b_mag >> ((k - i) * P));
    pp        = {{P{1'b0}}, a_dig} * {{P{1'b0}}, b_dig};
    s         = acc + ACC_W'(pp);
    last_pair = (i == col_hi(k, op.d));
    close_d   = (state == ACCUM) ? s[P-1:0] : acc[P-1:0];
    tneg      = {1'b0, ~close_d} + (P+1)'(ncarry);
    out_d     = op.neg ? tneg[P-1:0] : close_d;
    nc_nxt    = op.neg ? tneg[P] : ncarry;
    k_pen     = {op.d, 1'b0} - K_W'(2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = ACCUM;
      ACCUM: if (last_pair) state_nxt = EMIT;
      EMIT:  if (p_ready) begin
               if (p_last_reg)      state_nxt = IDLE;
               else if (k != k_pen) state_nxt = ACCUM;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op         <= '0;
      acc        <= '0;
      k          <= '0;
      i          <= '0;
      ncarry     <= 1'b0;
      p_reg      <= '0;
      p_last_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op         <= op_new;
          ncarry     <= op_new.neg;
          acc        <= '0;
          k          <= '0;
          i          <= '0;
          p_last_reg <= 1'b0;
        end
        ACCUM: if (last_pair) begin
          acc    <= s >> P;
          p_reg  <= out_d;
          ncarry <= nc_nxt;
        end else begin
          acc <= s;
          i   <= i + 1'b1;
        end
        EMIT: if (p_ready) begin
          if (p_last_reg) begin
            p_last_reg <= 1'b0;
          end else if (k == k_pen) begin
            // top column has no pairs: close it straight from the carry
            p_reg      <= out_d;
            ncarry     <= nc_nxt;
            acc        <= acc >> P;
            k          <= k + 1'b1;
            p_last_reg <= 1'b1;
          end else begin
            k <= k + 1'b1;
            i <= col_lo(k + 1'b1, op.d);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign p_valid  = (state == EMIT);
  assign p        = p_reg;
  assign p_last   = p_last_reg;
endmodule

// File: doc/digit_serial_mult.md
Name: digit_serial_mult

Overview:
- Digit-serial multiplier that takes two operands in parallel and streams the 2N-bit product out LSB-digit first, P bits per digit.
- Successor to the fixed-P, externally sequenced serial multiplier: it is parametrised in digit width and has its own sequencing FSM.
- Adds a runtime operand width, signed/unsigned mode and valid/ready handshakes on both sides.
- Sits between operand fetch and the serial result path of the compute array.

Parameters:
- P, 2, digit width in bits (>=1).
- MAX_WIDTH, 16, maximum operand width in bits; must be a multiple of P.
- MAX_D (derived), MAX_WIDTH/P, maximum operand length in digits.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts an operand pair.
- a  in  MAX_WIDTH  multiplicand; only bits [N-1:0] used.
- b  in  MAX_WIDTH  multiplier; only bits [N-1:0] used.
- num_digits  in  $clog2(MAX_D)+1  operand length D in digits; N = D*P. Sampled on accept.
- signed_mode  in  1  1: operands are two's complement N-bit values. Sampled on accept.
- p_valid  out  1  product digit valid.
- p_ready  in  1  consumer takes the digit.
- p  out  P  product digit.
- p_last  out  1  marks digit 2D-1.
- busy  out  1  operation in progress (state != IDLE).

Behaviour:
- Function:
  - Product R = a[N-1:0]*b[N-1:0] mod 2^(2N), interpreted signed or unsigned per signed_mode.
  - Digit k = R[k*P +: P], for k = 0..2D-1, emitted in order.
- num_digits handling: a value of 0 or a value > MAX_D is treated as MAX_D.
- FSM states: IDLE, ACCUM, EMIT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready (accept):
    - latch |a| and |b| as N-bit unsigned values (abs applies only when signed_mode and the sign bit is set; -2^(N-1) maps to 2^(N-1));
    - latch neg = signed_mode & (a[N-1]^b[N-1]);
    - set ncarry=neg, acc=0, column k=0;
    - go to ACCUM.
  - in_ready=0 in every other state. in_valid outside IDLE is ignored.
- Column schedule:
  - Column k sums every partial product A_i*B_j with i+j=k, where A_i and B_j are P-bit magnitude digits.
  - Pairs are visited with i ascending from max(0,k-D+1) to min(k,D-1), and j=k-i.
  - ACCUM adds one pair per cycle: acc += A_i*B_j.
- Column close (on the cycle that adds the last pair of the column):
  - s = acc + pp.
  - Raw digit d = s[P-1:0]; acc <= s>>P.
  - p <= neg ? (~d + ncarry) mod 2^P : d; ncarry <= carry-out of (~d + ncarry) when neg.
  - Go to EMIT. p_valid rises the following cycle.
- acc width: 2P+$clog2(MAX_D)+1 bits. It must never overflow.
- Column 2D-1 has no pairs. On the p_valid&p_ready handshake of digit 2D-2, the same column-close transform is applied to d=acc[P-1:0] with no ACCUM cycle. The block stays in EMIT and presents digit 2D-1 the next cycle with p_last=1.
- EMIT:
  - p, p_last and p_valid=1 are held stable until p_ready.
  - On handshake of a non-final digit with a non-empty next column: k++, go to ACCUM, p_valid=0.
  - On handshake with p_last=1: go to IDLE, p_valid=0. in_ready=1 the next cycle; there is no back-to-back accept in the same cycle.
- Cycle count with p_ready held high: column k takes pairs(k) ACCUM cycles plus 1 EMIT cycle; the final column takes 1 EMIT cycle. For D=1: accept at T, ACCUM at T+1, digit0 valid at T+2, digit1 valid at T+3.
- Reset (asynchronous, any state, including mid-operation):
  - State=IDLE; all registers cleared.
  - Outputs: p_valid=0, p=0, p_last=0, busy=0, in_ready=1 (immediately on assertion).
  - No partial output is produced after reset deasserts.

Test Plan:
- P=2, D=2, unsigned, a=4'hB, b=4'hD, p_ready=1 -> R=143=8'h8F. Digits 3,3,0,2; p_last only on the 4th digit; digit0 p_valid 2 cycles after accept.
- P=2, D=2, signed, a=4'b1110 (-2), b=4'b0011 (3) -> R=8'hFA. Digits 2,2,3,3.
- P=2, D=8, signed, a=b=16'h8000 -> R=32'h40000000. Digits 0 x15, then 1. No accumulator overflow. Repeat unsigned with a=b=16'hFFFF -> R=32'hFFFE0001.
- D=1, P=2, unsigned, a=3, b=3 -> digit0 at T+2 =1, digit1 at T+3 =2. in_ready=1 at T+4. in_valid pulsed at T+2 is ignored.
- Backpressure: as the first scenario, with p_ready low for 5 cycles while digit1 is valid -> p=3 and p_valid=1 stay stable; digit sequence unchanged; total latency +5 cycles.
- Reset asserted in ACCUM of column 2 -> p_valid=0 and in_ready=1 immediately. After release, a new operation (a=4'h5, b=4'h6, unsigned, D=2) gives digits 2,3,1,0 (R=30).
